// File: rtl/branch_resolution_controller.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolution_controller
// Brief    : In-order predicted-branch tracker; trains the predictor and
//            sequences flush/redirect on a mispredict.
// Revision : 1.0
// ============================================================================
module branch_resolution_controller #(
  parameter int DEPTH        = 4,
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_alloc_valid,
  input  logic                   i_alloc_predict,
  input  logic [PC_W-1:0]        i_alloc_target,
  input  logic [PC_W-1:0]        i_alloc_fallthrough,
  output logic                   o_alloc_ready,
  input  logic                   i_resolve_valid,
  input  logic                   i_resolve_taken,
  output logic                   o_pred_update_valid,
  output logic                   o_pred_update_taken,
  output logic                   o_flush,
  output logic                   o_redirect_valid,
  output logic [PC_W-1:0]        o_redirect_pc,
  output logic [$clog2(DEPTH):0] o_occupancy,
  output logic                   o_resolve_error,
  output logic [CNT_W-1:0]       o_branch_count,
  output logic [CNT_W-1:0]       o_mispredict_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int OW  = AW + 1;
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [OW-1:0]  c_DEPTH       = OW'(DEPTH);
  localparam logic [FCW-1:0] c_FLUSH_LOAD  = FCW'(FLUSH_CYCLES);
  localparam logic [FCW-1:0] c_FLUSH_LAST  = FCW'(1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [FCW-1:0]  r_flush_cnt;
  logic [FCW-1:0]  w_flush_cnt_nxt;

  logic            r_mem_pred [DEPTH];
  logic [PC_W-1:0] r_mem_tgt  [DEPTH];
  logic [PC_W-1:0] r_mem_ft   [DEPTH];

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [OW-1:0]   r_occ;

  logic            r_upd_valid;
  logic            r_upd_taken;
  logic            r_redirect_valid;
  logic [PC_W-1:0] r_redirect_pc;
  logic            r_resolve_error;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic            w_alloc_ready;
  logic            w_pop;
  logic            w_mispredict;
  logic            w_push;
  logic            w_err;
  logic            w_head_pred;
  logic [PC_W-1:0] w_head_tgt;
  logic [PC_W-1:0] w_head_ft;

  assign w_head_pred = r_mem_pred[r_rd_ptr];
  assign w_head_tgt  = r_mem_tgt[r_rd_ptr];
  assign w_head_ft   = r_mem_ft[r_rd_ptr];

  // Readiness looks only at registered state: a same-cycle pop never frees a full queue.
  assign w_alloc_ready = (r_state == RUN) && (r_occ < c_DEPTH);
  assign w_pop         = i_resolve_valid && (r_state == RUN) && (r_occ != '0);
  assign w_mispredict  = w_pop && (w_head_pred != i_resolve_taken);
  assign w_push        = i_alloc_valid && w_alloc_ready && !w_mispredict;
  assign w_err         = i_resolve_valid && (r_state == RUN) && (r_occ == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      RUN: begin
        if (w_mispredict) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = c_FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (r_flush_cnt == c_FLUSH_LAST) begin
          w_state_nxt     = RUN;
          w_flush_cnt_nxt = '0;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt     = RUN;
        w_flush_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pred[r_wr_ptr] <= i_alloc_predict;
      r_mem_tgt[r_wr_ptr]  <= i_alloc_target;
      r_mem_ft[r_wr_ptr]   <= i_alloc_fallthrough;
    end
  end

  // A mispredict empties the queue by snapping the read pointer onto the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (w_mispredict) begin
      r_rd_ptr <= r_wr_ptr;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_upd_valid      <= 1'b0;
      r_upd_taken      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_resolve_error  <= 1'b0;
      r_branch_cnt     <= '0;
      r_mispred_cnt    <= '0;
    end else begin
      r_upd_valid      <= w_pop;
      r_upd_taken      <= w_pop && i_resolve_taken;
      r_redirect_valid <= w_mispredict;
      r_resolve_error  <= w_err;
      if (w_mispredict) begin
        r_redirect_pc <= i_resolve_taken ? w_head_tgt : w_head_ft;
      end
      if (w_pop && (r_branch_cnt != '1)) begin
        r_branch_cnt <= r_branch_cnt + 1'b1;
      end
      if (w_mispredict && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
    end
  end

  assign o_alloc_ready       = w_alloc_ready;
  assign o_pred_update_valid = r_upd_valid;
  assign o_pred_update_taken = r_upd_taken;
  assign o_flush             = (r_state == FLUSH);
  assign o_redirect_valid    = r_redirect_valid;
  assign o_redirect_pc       = r_redirect_pc;
  assign o_occupancy         = r_occ;
  assign o_resolve_error     = r_resolve_error;
  assign o_branch_count      = r_branch_cnt;
  assign o_mispredict_count  = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolution_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolution_controller
// Brief    : Table-driven directed bench for branch_resolution_controller.
// Revision : 1.0
// ============================================================================
module tb_branch_resolution_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alloc_valid = 1'b0;
  logic        alloc_predict = 1'b0;
  logic [31:0] alloc_target = '0;
  logic [31:0] alloc_fallthrough = '0;
  logic        alloc_ready;
  logic        resolve_valid = 1'b0;
  logic        resolve_taken = 1'b0;
  logic        upd_valid;
  logic        upd_taken;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;
  logic        resolve_error;
  logic [3:0]  branch_count;
  logic [3:0]  mispredict_count;

  int tests  = 0;
  int failed = 0;

  branch_resolution_controller #(
    .DEPTH(4), .PC_W(32), .FLUSH_CYCLES(2), .CNT_W(4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_alloc_valid       (alloc_valid),
    .i_alloc_predict     (alloc_predict),
    .i_alloc_target      (alloc_target),
    .i_alloc_fallthrough (alloc_fallthrough),
    .o_alloc_ready       (alloc_ready),
    .i_resolve_valid     (resolve_valid),
    .i_resolve_taken     (resolve_taken),
    .o_pred_update_valid (upd_valid),
    .o_pred_update_taken (upd_taken),
    .o_flush             (flush),
    .o_redirect_valid    (redirect_valid),
    .o_redirect_pc       (redirect_pc),
    .o_occupancy         (occupancy),
    .o_resolve_error     (resolve_error),
    .o_branch_count      (branch_count),
    .o_mispredict_count  (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av, ap;
    logic [31:0] tgt, ft;
    logic        rv, rt;
    logic [2:0]  occ;
    logic        uv, ut, rdv;
    logic [31:0] rpc;
    logic        fl, err, rdy;
    logic [3:0]  bc, mc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic av, logic ap, logic [31:0] tgt, logic [31:0] ft,
                              logic rv, logic rt, logic [2:0] occ, logic uv, logic ut,
                              logic rdv, logic [31:0] rpc, logic fl, logic err, logic rdy,
                              logic [3:0] bc, logic [3:0] mc);
    vec_t v;
    v.av = av; v.ap = ap; v.tgt = tgt; v.ft = ft; v.rv = rv; v.rt = rt;
    v.occ = occ; v.uv = uv; v.ut = ut; v.rdv = rdv; v.rpc = rpc;
    v.fl = fl; v.err = err; v.rdy = rdy; v.bc = bc; v.mc = mc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic ap, input logic [31:0] tgt,
                       input logic [31:0] ft, input logic rv, input logic rt);
    alloc_valid = av; alloc_predict = ap; alloc_target = tgt; alloc_fallthrough = ft;
    resolve_valid = rv; resolve_taken = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic p [11];

  initial begin
    p = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Straight-line allocate/resolve, full queue, same-cycle pop blocked alloc
    tbl.push_back(mk(1,0,0,0, 0,0, 1,0,0,0,0, 0,0,1, 0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 2,0,0,0,0, 0,0,1, 0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 3,0,0,0,0, 0,0,1, 0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 4,0,0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(1,1,0,0, 1,0, 3,1,0,0,0, 0,0,1, 1,0));
    tbl.push_back(mk(0,0,0,0, 1,1, 2,1,1,0,0, 0,0,1, 2,0));
    tbl.push_back(mk(0,0,0,0, 1,1, 1,1,1,0,0, 0,0,1, 3,0));
    tbl.push_back(mk(0,0,0,0, 1,0, 0,1,0,0,0, 0,0,1, 4,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,0,0, 0,0,1, 4,0));
    // Mispredict with fallthrough redirect; resolve and alloc during flush ignored
    tbl.push_back(mk(1,1,32'h100,32'h8,  0,0, 1,0,0,0,0, 0,0,1, 4,0));
    tbl.push_back(mk(1,0,32'h200,32'h10, 0,0, 2,0,0,0,0, 0,0,1, 4,0));
    tbl.push_back(mk(1,1,32'h400,32'h40, 0,0, 3,0,0,0,0, 0,0,1, 4,0));
    tbl.push_back(mk(0,0,0,0, 1,0, 0,1,0,1,32'h8, 1,0,0, 5,1));
    tbl.push_back(mk(1,1,32'h600,32'h60, 1,1, 0,0,0,0,0, 1,0,0, 5,1));
    tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,0,0, 0,0,1, 5,1));
    // Alloc coinciding with a mispredict is dropped; taken-target redirect
    tbl.push_back(mk(1,0,32'h300,32'h30, 0,0, 1,0,0,0,0, 0,0,1, 5,1));
    tbl.push_back(mk(1,1,32'h500,32'h50, 0,0, 2,0,0,0,0, 0,0,1, 5,1));
    tbl.push_back(mk(1,1,32'h700,32'h70, 1,1, 0,1,1,1,32'h300, 1,0,0, 6,2));
    tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,0,0, 1,0,0, 6,2));
    tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,0,0, 0,0,1, 6,2));
    // Empty resolve raises an error and nothing else
    tbl.push_back(mk(0,0,0,0, 1,1, 0,0,0,0,0, 0,1,1, 6,2));
    tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,0,0, 0,0,1, 6,2));
    // Alloc coinciding with a correct resolve keeps occupancy and order
    tbl.push_back(mk(1,1,0,0, 0,0, 1,0,0,0,0, 0,0,1, 6,2));
    tbl.push_back(mk(1,0,0,0, 0,0, 2,0,0,0,0, 0,0,1, 6,2));
    tbl.push_back(mk(1,1,0,0, 1,1, 2,1,1,0,0, 0,0,1, 7,2));
    tbl.push_back(mk(0,0,0,0, 1,0, 1,1,0,0,0, 0,0,1, 8,2));
    tbl.push_back(mk(0,0,0,0, 1,1, 0,1,1,0,0, 0,0,1, 9,2));
    // Steady-state pairs wrap the pointers; branch_count saturates at 15
    tbl.push_back(mk(1,p[0],0,0, 0,0, 1,0,0,0,0, 0,0,1, 9,2));
    for (int k = 1; k <= 10; k++) begin
      tbl.push_back(mk(1,p[k],0,0, 1,p[k-1], 1,1,p[k-1],0,0, 0,0,1,
                       4'((9 + k > 15) ? 15 : 9 + k), 2));
    end
    tbl.push_back(mk(0,0,0,0, 1,p[10], 0,1,p[10],0,0, 0,0,1, 15,2));
    tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,0,0, 0,0,1, 15,2));

    // Reset values, sampled while reset is still held
    step();
    check("rst_occ",   32'(occupancy), 0);
    check("rst_ready", 32'(alloc_ready), 1);
    check("rst_flush", 32'(flush), 0);
    check("rst_upd",   32'(upd_valid), 0);
    check("rst_rdv",   32'(redirect_valid), 0);
    check("rst_err",   32'(resolve_error), 0);
    check("rst_bc",    32'(branch_count), 0);
    check("rst_mc",    32'(mispredict_count), 0);
    step();
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].av, tbl[i].ap, tbl[i].tgt, tbl[i].ft, tbl[i].rv, tbl[i].rt);
      step();
      check($sformatf("v%0d_occ", i),   32'(occupancy),      32'(tbl[i].occ));
      check($sformatf("v%0d_upd", i),   32'(upd_valid),      32'(tbl[i].uv));
      if (tbl[i].uv)
        check($sformatf("v%0d_taken", i), 32'(upd_taken),    32'(tbl[i].ut));
      check($sformatf("v%0d_rdv", i),   32'(redirect_valid), 32'(tbl[i].rdv));
      if (tbl[i].rdv)
        check($sformatf("v%0d_rpc", i), redirect_pc,         tbl[i].rpc);
      check($sformatf("v%0d_flush", i), 32'(flush),          32'(tbl[i].fl));
      check($sformatf("v%0d_err", i),   32'(resolve_error),  32'(tbl[i].err));
      check($sformatf("v%0d_ready", i), 32'(alloc_ready),    32'(tbl[i].rdy));
      check($sformatf("v%0d_bc", i),    32'(branch_count),   32'(tbl[i].bc));
      check($sformatf("v%0d_mc", i),    32'(mispredict_count), 32'(tbl[i].mc));
    end

    // 17 mispredicts saturate mispredict_count at 15
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 32'h20, 32'h4, 0, 0);
      step();
      drive(0, 0, 0, 0, 1, 1);
      step();
      drive(0, 0, 0, 0, 0, 0);
      step();
      step();
    end
    check("sat_mc", 32'(mispredict_count), 15);
    check("sat_bc", 32'(branch_count), 15);

    // Asynchronous reset mid-flush
    drive(1, 0, 32'h20, 32'h4, 0, 0);
    step();
    drive(1, 1, 32'h24, 32'h8, 0, 0);
    step();
    check("pre_occ", 32'(occupancy), 2);
    drive(0, 0, 0, 0, 1, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("mid_flush", 32'(flush), 1);
    check("mid_rdv",   32'(redirect_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_flush", 32'(flush), 0);
    check("arst_rdv",   32'(redirect_valid), 0);
    check("arst_ready", 32'(alloc_ready), 1);
    check("arst_mc",    32'(mispredict_count), 0);
    check("arst_bc",    32'(branch_count), 0);
    step();
    reset = 1'b0;

    // Asynchronous reset with entries outstanding
    drive(1, 1, 0, 0, 0, 0);
    step();
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("pre2_occ", 32'(occupancy), 2);
    #2 reset = 1'b1;
    #1;
    check("arst_occ", 32'(occupancy), 0);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("post_rst_err", 32'(resolve_error), 1);
    check("post_rst_upd", 32'(upd_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
